// File: rtl/vjtag_readback.sv
// Virtual-JTAG readback transmitter: snapshots a fabric word and shifts it out LSB-first on tdo
// while the host scans the DR under IR READ. Define VJTAG_RB_HEADER_EN to prepend an 8-bit header.
module vjtag_readback #(
  parameter int W  = 491,
  parameter int CW = 10
) (
  input  logic         tck,
  input  logic         aclr,
  input  logic [2:0]   ir_in,
  input  logic         v_cdr,
  input  logic         v_sdr,
  input  logic         v_udr,
  input  logic         tdi,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ack,
  output logic         tdo,
  output logic         rd_done,
  output logic         rd_short,
  output logic         busy
);

  localparam logic [2:0] IR_READ = 3'b010;
`ifdef VJTAG_RB_HEADER_EN
  localparam int L = W + 8;
`else
  localparam int L = W;
`endif

  typedef enum logic [1:0] {IDLE, LOADED, SHIFT} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   snap;
  logic           fresh;
  logic [L-1:0]   sr;
  logic [L-1:0]   frame;
  logic           byp;
  logic [CW-1:0]  bcnt;
  logic [3:0]     seq;

  logic is_read, capture, accept, shift_en, update, abandon, full;

  assign is_read  = (ir_in == IR_READ);
  assign capture  = v_cdr && is_read && (state != SHIFT);
  // Ack is a registered pulse, so a source still holding in_valid during the ack
  // cycle must not be accepted a second time.
  assign accept   = in_valid && !capture && (state != SHIFT) && !in_ack;
  assign shift_en = v_sdr && is_read && (state == SHIFT);
  assign update   = v_udr && is_read && (state == SHIFT);
  assign abandon  = v_cdr && !is_read && (state == SHIFT);
  assign full     = (bcnt >= CW'(L));

`ifdef VJTAG_RB_HEADER_EN
  assign frame = {snap, fresh, 3'b101, seq};
`else
  assign frame = snap;
`endif

  assign tdo = is_read ? sr[0] : byp;

  // NOTE: every variable in a combinational block gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, LOADED: begin
        if (capture)     state_nx = SHIFT;
        else if (accept) state_nx = LOADED;
      end
      SHIFT: begin
        if (update)       state_nx = (full || !fresh) ? IDLE : LOADED;
        else if (abandon) state_nx = fresh ? LOADED : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of statement order. snap and sr are flops rather than
  // a memory, so they take the clear along with the control state.
  always_ff @(posedge tck) begin
    if (aclr) begin
      state    <= IDLE;
      snap     <= '0;
      fresh    <= 1'b0;
      sr       <= '0;
      byp      <= 1'b0;
      bcnt     <= '0;
      seq      <= '0;
      in_ack   <= 1'b0;
      rd_done  <= 1'b0;
      rd_short <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx == SHIFT);
      byp      <= tdi;
      in_ack   <= accept;
      rd_done  <= update && full;
      rd_short <= update && !full;

      if (accept) begin
        snap  <= in_data;
        fresh <= 1'b1;
      end

      if (update && full) begin
        fresh <= 1'b0;
        seq   <= seq + 4'd1;
      end

      if (capture) begin
        sr   <= frame;
        bcnt <= '0;
      end else if (shift_en) begin
        sr <= {tdi, sr[L-1:1]};
        if (bcnt != '1) bcnt <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vjtag_readback.sv
// Randomized scoreboard bench for vjtag_readback: a queue-based frame model predicts tdo bits
// and handshake pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_vjtag_readback;

  localparam int W  = 491;
  localparam int CW = 10;
`ifdef VJTAG_RB_HEADER_EN
  localparam int L = W + 8;
`else
  localparam int L = W;
`endif
  localparam logic [2:0] RD = 3'b010;

  logic         tck = 1'b0;
  logic         aclr = 1'b1;
  logic [2:0]   ir_in = 3'b000;
  logic         v_cdr = 1'b0, v_sdr = 1'b0, v_udr = 1'b0, tdi = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ack, tdo, rd_done, rd_short, busy;

  vjtag_readback #(.W(W), .CW(CW)) dut (
    .tck(tck), .aclr(aclr), .ir_in(ir_in), .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr),
    .tdi(tdi), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack), .tdo(tdo),
    .rd_done(rd_done), .rd_short(rd_short), .busy(busy)
  );

  always #5 tck = ~tck;

  int checks = 0;
  int failures = 0;

  // Scoreboard: expected tdo bits per host shift, expected {in_ack, rd_done, rd_short} pulses.
  bit         exp_bits[$];
  logic [2:0] exp_ev[$];

  // Reference model: the frame is a bit queue in transmit order; shifting pops the front
  // and appends the host bit at the back.
  logic [W-1:0] m_snap;
  bit           m_fresh;
  int           m_seq;
  bit           m_shift;
  int           m_cnt;
  bit           m_frame[$];
  bit           m_last_tdi;
  bit           src_valid;
  logic [W-1:0] src_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT output with nothing expected at %0t", name, $time);
  endtask

  always @(negedge tck) begin
    logic [2:0] ev;
    if (!aclr) begin
      if (busy && v_sdr && ir_in == RD) begin
        if (exp_bits.size() == 0) fail_now("tdo_bit");
        else check("tdo_bit", 32'(tdo), 32'(exp_bits.pop_front()));
      end
      ev = {in_ack, rd_done, rd_short};
      if (ev != 3'b000) begin
        if (exp_ev.size() == 0) fail_now("pulse");
        else check("pulse", 32'(ev), 32'(exp_ev.pop_front()));
      end
    end
  end

  task automatic build_frame();
    m_frame.delete();
`ifdef VJTAG_RB_HEADER_EN
    for (int i = 0; i < 4; i++) m_frame.push_back(bit'((m_seq >> i) & 1));
    m_frame.push_back(1'b1);
    m_frame.push_back(1'b0);
    m_frame.push_back(1'b1);
    m_frame.push_back(m_fresh);
`endif
    for (int i = 0; i < W; i++) m_frame.push_back(m_snap[i]);
  endtask

  // One tck cycle: drive inputs, advance the model by the same rules, then clock.
  task automatic step(input bit cdr, input bit sdr, input bit udr, input logic [2:0] ir,
                      input bit t, input bit chk_byp = 1'b0);
    bit rd, cap, acc;
    rd  = (ir == RD);
    cap = cdr && rd && !m_shift;
    acc = src_valid && !m_shift && !cap;
    v_cdr = cdr; v_sdr = sdr; v_udr = udr; ir_in = ir; tdi = t;
    in_valid = src_valid; in_data = src_data;
    if (chk_byp && !rd) begin
      #1;
      check("bypass", 32'(tdo), 32'(m_last_tdi));
    end
    if (m_shift && sdr && rd) begin
      exp_bits.push_back(m_frame.pop_front());
      m_frame.push_back(t);
      m_cnt++;
    end else if (m_shift && udr && rd) begin
      if (m_cnt >= L) begin
        exp_ev.push_back(3'b010);
        m_fresh = 1'b0;
        m_seq = (m_seq + 1) % 16;
      end else begin
        exp_ev.push_back(3'b001);
      end
      m_shift = 1'b0;
    end else if (m_shift && cdr && !rd) begin
      m_shift = 1'b0;
    end
    if (cap) begin
      build_frame();
      m_cnt = 0;
      m_shift = 1'b1;
    end
    if (acc) begin
      m_snap = src_data;
      m_fresh = 1'b1;
      src_valid = 1'b0;
      exp_ev.push_back(3'b100);
    end
    m_last_tdi = t;
    @(posedge tck);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, RD, 1'b0);
  endtask

  task automatic load(input logic [W-1:0] d);
    src_data = d;
    src_valid = 1'b1;
    idle(2);
  endtask

  // Capture, nshift host shifts, then optionally update; a trailing idle lets pulses show.
  task automatic scan(input int nshift, input bit do_update = 1'b1);
    step(1'b1, 1'b0, 1'b0, RD, 1'b0);
    for (int i = 0; i < nshift; i++) step(1'b0, 1'b1, 1'b0, RD, bit'($urandom_range(0, 1)));
    if (do_update) step(1'b0, 1'b0, 1'b1, RD, 1'b0);
    idle(1);
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    v_cdr = 1'b0; v_sdr = 1'b0; v_udr = 1'b0; tdi = 1'b0; in_valid = 1'b0;
    src_valid = 1'b0;
    @(posedge tck);
    #1;
    aclr = 1'b0;
    m_snap = '0; m_fresh = 1'b0; m_seq = 0; m_shift = 1'b0; m_cnt = 0; m_last_tdi = 1'b0;
    m_frame.delete();
    ir_in = RD;
    #1;
    check("rst_in_ack", 32'(in_ack), 32'd0);
    check("rst_rd_done", 32'(rd_done), 32'd0);
    check("rst_rd_short", 32'(rd_short), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tdo_read", 32'(tdo), 32'd0);
    ir_in = 3'b000;
    #1;
    check("rst_tdo_bypass", 32'(tdo), 32'd0);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    logic [63:0]  base;
    logic [W-1:0] pat;
    logic [2:0]   irx;

    src_data = '0;
    do_reset();

    // Read with nothing loaded returns the cleared snapshot.
    scan(L);

    // Known pattern with both end bits set.
    base = 64'h1_2345_6789_ABCD_EF0;
    for (int i = 0; i < W; i++) pat[i] = base[i % 64];
    pat[0] = 1'b1;
    pat[W-1] = 1'b1;
    load(pat);
    scan(L);

    // in_valid together with capture: the capture wins, the word lands after the update.
    load(rand_word());
    src_data = rand_word();
    src_valid = 1'b1;
    scan(L);
    idle(2);
    scan(L);

    // Short update keeps fresh; full rescan returns the same word.
    load(rand_word());
    scan(100);
    scan(L);

    // IR change mid-scan abandons silently; the data is still fresh afterwards.
    load(rand_word());
    step(1'b1, 1'b0, 1'b0, RD, 1'b0);
    for (int i = 0; i < 37; i++) step(1'b0, 1'b1, 1'b0, RD, bit'($urandom_range(0, 1)));
    step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    idle(1);
    scan(L);

    // Over-shifting past the counter saturation point still counts as complete.
    load(rand_word());
    scan((1 << CW) + 6);

    // Bypass path: tdo follows the previous tdi under any non-READ code.
    for (int i = 0; i < 12; i++) begin
      irx = 3'($urandom_range(0, 7));
      if (irx == RD) irx = 3'b111;
      step(1'b0, 1'b0, 1'b0, irx, bit'($urandom_range(0, 1)), 1'b1);
    end

    // Randomized mix of loads, full, short, over-length and concurrent-valid scans.
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 4))
        0: load(rand_word());
        1: scan(L + int'($urandom_range(0, 3)));
        2: scan(int'($urandom_range(1, L - 1)));
        3: begin
          src_data = rand_word();
          src_valid = 1'b1;
          scan(L);
          idle(2);
        end
        default: begin
          load(rand_word());
          scan(L);
        end
      endcase
    end

    // Reset mid-scan aborts without pulses and clears the snapshot.
    load(rand_word());
    scan(200, 1'b0);
    do_reset();
    scan(L);

    idle(3);
    check("bits_left", 32'(exp_bits.size()), 32'd0);
    check("events_left", 32'(exp_ev.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
